// File: rtl/joybus_pkg.sv
// Shared types, quarter-bit line patterns and the bit encoder for the Joybus transmitter.
package joybus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_e;

    // Bit [3] is the first quarter on the wire; 1 means pull the line low.
    localparam logic [3:0] Q_ZERO      = 4'b1110;
    localparam logic [3:0] Q_ONE       = 4'b1000;
    localparam logic [3:0] Q_STOP_CTRL = 4'b1100;
    localparam logic [3:0] Q_STOP_CONS = 4'b1000;

    function automatic logic [3:0] encode_bit(input logic b);
        return b ? Q_ONE : Q_ZERO;
    endfunction

    function automatic logic [3:0] stop_pattern(input logic console);
        return console ? Q_STOP_CONS : Q_STOP_CTRL;
    endfunction

endpackage

// File: rtl/joybus_quarter_timer.sv
// Quarter-bit timebase: LEVEL_CYCLES clocks per quarter, four quarters per bit.
module joybus_quarter_timer #(
    parameter int LEVEL_CYCLES = 2
) (
    input  logic       sample_clk,
    input  logic       reset_n,
    input  logic       clear_i,
    output logic [1:0] quarter_idx_o,
    output logic       quarter_end_o,
    output logic       bit_end_o
);

    localparam int SUB_W = (LEVEL_CYCLES > 1) ? $clog2(LEVEL_CYCLES) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(LEVEL_CYCLES - 1);

    logic [SUB_W-1:0] sub_q, sub_d;
    logic [1:0]       qidx_q, qidx_d;

    assign quarter_end_o = (sub_q == SUB_LAST);
    assign bit_end_o     = quarter_end_o && (qidx_q == 2'd3);
    assign quarter_idx_o = qidx_q;

    always_comb begin
        sub_d  = sub_q;
        qidx_d = qidx_q;
        if (clear_i) begin
            sub_d  = '0;
            qidx_d = 2'd0;
        end else if (quarter_end_o) begin
            sub_d  = '0;
            qidx_d = qidx_q + 2'd1;
        end else begin
            sub_d  = sub_q + SUB_W'(1);
        end
    end

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            sub_q  <= '0;
            qidx_q <= 2'd0;
        end else begin
            sub_q  <= sub_d;
            qidx_q <= qidx_d;
        end
    end

endmodule

// File: rtl/joybus_tx.sv
// Joybus line transmitter: variable-length MSB-first frame plus selectable stop bit
// onto an open-drain pad enable.
module joybus_tx
    import joybus_pkg::*;
#(
    parameter int LEVEL_CYCLES = 2,
    parameter int MAX_BYTES    = 4,
    parameter int LEN_W        = $clog2(MAX_BYTES + 1)
) (
    input  logic                   sample_clk,
    input  logic                   reset_n,
    input  logic                   tx_start,
    input  logic [LEN_W-1:0]       tx_len,
    input  logic [8*MAX_BYTES-1:0] tx_payload,
    input  logic                   console_stop,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic                   tx_err,
    output logic                   line_drive_low
);

    localparam int PW = 8 * MAX_BYTES;
    localparam int BW = LEN_W + 3;

    state_e          state_q, state_d;
    logic [PW-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]   bits_q, bits_d;
    logic            cons_q, cons_d;
    logic            drive_q, drive_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [1:0]      quarter_idx;
    logic            quarter_end;
    logic            bit_end;
    logic [1:0]      q_next;
    logic [3:0]      pat_cur;
    logic            len_ok;
    logic            last_bit;

    joybus_quarter_timer #(
        .LEVEL_CYCLES(LEVEL_CYCLES)
    ) u_timer (
        .sample_clk   (sample_clk),
        .reset_n      (reset_n),
        .clear_i      (state_q == IDLE),
        .quarter_idx_o(quarter_idx),
        .quarter_end_o(quarter_end),
        .bit_end_o    (bit_end)
    );

    assign len_ok   = (tx_len != '0) && (tx_len <= LEN_W'(MAX_BYTES));
    assign last_bit = (bits_q == BW'(1));
    // Drive is registered, so it is computed from the quarter that starts next cycle.
    assign q_next   = quarter_end ? (quarter_idx + 2'd1) : quarter_idx;

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bits_q  <= '0;
            cons_q  <= 1'b0;
            drive_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bits_q  <= bits_d;
            cons_q  <= cons_d;
            drive_q <= drive_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (tx_start && len_ok) state_d = DATA;
            DATA:    if (bit_end && last_bit) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shreg_d = shreg_q;
        bits_d  = bits_q;
        cons_d  = cons_q;
        drive_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pat_cur = (state_q == STOP) ? stop_pattern(cons_q) : encode_bit(shreg_q[PW-1]);
        unique case (state_q)
            IDLE: begin
                if (tx_start) begin
                    if (len_ok) begin
                        // Left-align so the first bit to send sits at the MSB.
                        shreg_d = tx_payload << (8 * (MAX_BYTES - int'(tx_len)));
                        bits_d  = {tx_len, 3'b000};
                        cons_d  = console_stop;
                        drive_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q << 1;
                    bits_d  = bits_q - BW'(1);
                    drive_d = 1'b1;
                end else begin
                    drive_d = pat_cur[2'd3 - q_next];
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                end else begin
                    drive_d = pat_cur[2'd3 - q_next];
                end
            end
            default: begin
                drive_d = 1'b0;
            end
        endcase
    end

    assign tx_busy        = (state_q != IDLE);
    assign tx_done        = done_q;
    assign tx_err         = err_q;
    assign line_drive_low = drive_q;

endmodule

// File: tb/tb_joybus_tx.sv
// Directed bench for joybus_tx at LEVEL_CYCLES 2 (main), 1 and 5 (sweep).
module tb_joybus_tx;

    localparam int MAXC = 800;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        st_a, st_b, st_c;
    logic [2:0]  tx_len;
    logic [31:0] tx_payload;
    logic        console_stop;

    logic busy_a, done_a, err_a, drv_a;
    logic busy_b, done_b, err_b, drv_b;
    logic busy_c, done_c, err_c, drv_c;

    int   sel;
    logic drv_m, busy_m, done_m, err_m;

    int   n_assert = 0;
    int   n_fail   = 0;
    logic drv_log [0:MAXC];
    int   done_at, busy_cnt, err_seen;

    always #5 clk = ~clk;

    joybus_tx #(.LEVEL_CYCLES(2), .MAX_BYTES(4)) dut_a (
        .sample_clk(clk), .reset_n(reset_n), .tx_start(st_a), .tx_len(tx_len),
        .tx_payload(tx_payload), .console_stop(console_stop), .tx_busy(busy_a),
        .tx_done(done_a), .tx_err(err_a), .line_drive_low(drv_a));

    joybus_tx #(.LEVEL_CYCLES(1), .MAX_BYTES(4)) dut_b (
        .sample_clk(clk), .reset_n(reset_n), .tx_start(st_b), .tx_len(tx_len),
        .tx_payload(tx_payload), .console_stop(console_stop), .tx_busy(busy_b),
        .tx_done(done_b), .tx_err(err_b), .line_drive_low(drv_b));

    joybus_tx #(.LEVEL_CYCLES(5), .MAX_BYTES(4)) dut_c (
        .sample_clk(clk), .reset_n(reset_n), .tx_start(st_c), .tx_len(tx_len),
        .tx_payload(tx_payload), .console_stop(console_stop), .tx_busy(busy_c),
        .tx_done(done_c), .tx_err(err_c), .line_drive_low(drv_c));

    always_comb begin
        drv_m = drv_a; busy_m = busy_a; done_m = done_a; err_m = err_a;
        if (sel == 1) begin
            drv_m = drv_b; busy_m = busy_b; done_m = done_b; err_m = err_b;
        end else if (sel == 2) begin
            drv_m = drv_c; busy_m = busy_c; done_m = done_c; err_m = err_c;
        end
    end

    function automatic int lvl(input int s);
        return (s == 0) ? 2 : ((s == 1) ? 1 : 5);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 0) st_a = v;
        else if (s == 1) st_b = v;
        else st_c = v;
    endtask

    // Expected pad enable for sample j (1 = first cycle after the accepting edge).
    function automatic logic exp_drv(input int j, input int len, input logic [31:0] pl,
                                     input logic cons, input int l);
        int idx, bitn, q;
        logic [3:0] pat;
        idx  = j - 1;
        bitn = idx / (4 * l);
        q    = (idx % (4 * l)) / l;
        if (bitn < 8 * len) pat = pl[8*len-1-bitn] ? 4'b1000 : 4'b1110;
        else                pat = cons ? 4'b1000 : 4'b1100;
        return pat[3-q];
    endfunction

    // Second quarter released means a 1 bit.
    function automatic logic [31:0] decode(input int len, input int l);
        logic [31:0] v = '0;
        for (int i = 0; i < 8 * len; i++)
            v = {v[30:0], ~drv_log[i*4*l + l + 1]};
        return v;
    endfunction

    task automatic run_frame(input int s, input int len, input logic [31:0] pl,
                             input logic cons, input int inj_at, input logic [31:0] inj_pl);
        sel = s;
        tx_len = 3'(len);
        tx_payload = pl;
        console_stop = cons;
        set_start(s, 1'b1);
        done_at = 0; busy_cnt = 0; err_seen = 0;
        for (int j = 1; j <= MAXC && done_at == 0; j++) begin
            @(negedge clk);
            if (j == 1 || (inj_at > 0 && j == inj_at + 1)) set_start(s, 1'b0);
            drv_log[j] = drv_m;
            if (busy_m) busy_cnt++;
            if (err_m) err_seen++;
            if (done_m) done_at = j;
            if (inj_at > 0 && j == inj_at) begin
                tx_payload = inj_pl;
                set_start(s, 1'b1);
            end
        end
    endtask

    task automatic check_frame(input string tag, input int s, input int len,
                               input logic [31:0] pl, input logic cons);
        int l, n, mism;
        l = lvl(s);
        n = (8 * len + 1) * 4 * l;
        mism = 0;
        for (int j = 1; j <= n; j++)
            if (drv_log[j] !== exp_drv(j, len, pl, cons, l)) mism++;
        if (drv_log[n+1] !== 1'b0) mism++;
        check({tag, "_done_at"}, done_at, n + 1);
        check({tag, "_busy_cycles"}, busy_cnt, n);
        check({tag, "_wave_mismatches"}, mism, 0);
        check({tag, "_decoded"}, decode(len, l), pl);
        check({tag, "_err"}, err_seen, 0);
    endtask

    initial begin
        int dcount;
        sel = 0;
        st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
        tx_len = 3'd0; tx_payload = '0; console_stop = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_err", err_a, 0);
        check("reset_drive", drv_a, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // len 1, 0x80, controller stop
        run_frame(0, 1, 32'h80, 1'b0, 0, '0);
        check_frame("f1", 0, 1, 32'h80, 1'b0);
        check("f1_hand_points", {drv_log[2], drv_log[3], drv_log[8], drv_log[9],
                                 drv_log[15], drv_log[68], drv_log[69]}, 7'b1001010);
        @(negedge clk);
        check("f1_done_one_cycle", done_a, 0);
        check("f1_idle_drive", drv_a, 0);

        // len 3, console stop
        run_frame(0, 3, 32'h050000, 1'b1, 0, '0);
        check_frame("f2", 0, 3, 32'h050000, 1'b1);
        check("f2_stop", {drv_log[193], drv_log[194], drv_log[195], drv_log[200]}, 4'b1100);
        @(negedge clk);

        // rejected lengths
        for (int k = 0; k < 2; k++) begin
            tx_len = (k == 0) ? 3'd0 : 3'd5;
            st_a = 1'b1;
            @(negedge clk);
            st_a = 1'b0;
            check($sformatf("err%0d_pulse", k), err_a, 1);
            check($sformatf("err%0d_busy", k), busy_a, 0);
            check($sformatf("err%0d_drive", k), drv_a, 0);
            @(negedge clk);
            check($sformatf("err%0d_one_cycle", k), {err_a, busy_a, drv_a}, 3'b000);
        end

        // start while busy is ignored; start in done cycle is accepted
        run_frame(0, 2, 32'h1234, 1'b0, 20, 32'hFFFF);
        check_frame("f3", 0, 2, 32'h1234, 1'b0);
        run_frame(0, 1, 32'h01, 1'b1, 0, '0);
        check("b2b_gap_then_low", {drv_log[1]}, 1'b1);
        check_frame("f4", 0, 1, 32'h01, 1'b1);
        @(negedge clk);

        // async reset mid-frame
        tx_len = 3'd4; tx_payload = 32'h0F0F0F0F; console_stop = 1'b0;
        st_a = 1'b1;
        @(negedge clk);
        st_a = 1'b0;
        repeat (29) @(negedge clk);
        check("rst_pre_drive", drv_a, 1);
        reset_n = 1'b0;
        #1;
        check("rst_async_drive", drv_a, 0);
        check("rst_async_busy", busy_a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        dcount = 0;
        repeat (300) begin
            @(negedge clk);
            if (done_a || busy_a) dcount++;
        end
        check("rst_no_done", dcount, 0);
        run_frame(0, 1, 32'h5A, 1'b0, 0, '0);
        check_frame("f5", 0, 1, 32'h5A, 1'b0);
        @(negedge clk);

        // LEVEL_CYCLES sweep at full length
        run_frame(1, 4, 32'hA5A5A5A5, 1'b0, 0, '0);
        check_frame("l1", 1, 4, 32'hA5A5A5A5, 1'b0);
        @(negedge clk);
        run_frame(2, 4, 32'hA5A5A5A5, 1'b1, 0, '0);
        check_frame("l5", 2, 4, 32'hA5A5A5A5, 1'b1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/joybus_tx.md
Name: joybus_tx

Overview:
- Parametrised Joybus line transmitter, successor to the fake-controller responder's fixed-length TX path.
- Serialises a variable-length byte frame, MSB first, onto the open-drain Joybus data line, then appends a selectable stop bit.
- Sits between the command decoder / response builder and the bidirectional pad.
- Reports busy, done and length-error status; the RX side uses done to reclaim the line.

Parameters:
- LEVEL_CYCLES, 2: sample_clk cycles per quarter-bit (level). Must be ≥1.
- MAX_BYTES, 4: largest payload in bytes. Must be ≥1.
- LEN_W, $clog2(MAX_BYTES+1): width of the tx_len port (derived).

Ports:
- sample_clk  in  1  system clock; all logic rises on its posedge.
- reset_n  in  1  asynchronous, active-low reset.
- tx_start  in  1  single-cycle request to send a frame.
- tx_len  in  LEN_W  payload length in bytes; valid with tx_start.
- tx_payload  in  8*MAX_BYTES  right-aligned payload; the first bit sent is tx_payload[8*tx_len-1].
- console_stop  in  1  stop-bit select, sampled with tx_start. 1 = console stop (L,H,H,H); 0 = controller stop (L,L,H,H).
- tx_busy  out  1  high while a frame is in flight.
- tx_done  out  1  one-cycle pulse when the frame completes.
- tx_err  out  1  one-cycle pulse when tx_start is rejected.
- line_drive_low  out  1  registered pad enable. 1 = pull the line low; 0 = release it (pull-up gives H). Never drives high.

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state IDLE, counters 0. Asserting reset mid-frame releases the line immediately and produces no tx_done.
- States:
  - IDLE to DATA: tx_start=1 and 1≤tx_len≤MAX_BYTES. Latch tx_payload, tx_len and console_stop; load the bit counter with 8*tx_len.
  - IDLE to IDLE with tx_err=1 for one cycle: tx_start=1 and tx_len is 0 or greater than MAX_BYTES.
  - DATA to STOP: after the quarter-4 window of the last data bit ends.
  - STOP to IDLE: after the stop bit's fourth quarter. tx_done=1 and tx_busy=0 in that same cycle.
- tx_start while busy: ignored, no tx_err. Payload changes after acceptance have no effect.
- Timing:
  - Let edge k be the edge that accepts tx_start. tx_busy and line_drive_low become 1 after edge k.
  - Each bit is 4 quarters of LEVEL_CYCLES cycles each.
  - Total frame = (8*len+1)*4*LEVEL_CYCLES cycles. tx_done is high after edge k+(8*len+1)*4*LEVEL_CYCLES, for exactly one cycle.
- Quarter encoding (1 = drive low):
  - data 0 = 1,1,1,0
  - data 1 = 1,0,0,0
  - controller stop = 1,1,0,0
  - console stop = 1,0,0,0
- Back-to-back frames: tx_start in the tx_done cycle is accepted, since state is already IDLE at that edge. The line is released for that one cycle, then drives low again.
- Counters:
  - Quarter sub-counter wraps LEVEL_CYCLES-1 to 0.
  - Quarter index wraps 3 to 0.
  - Bit counter decrements at bit end, with no underflow: it reaches 0 exactly at the DATA-to-STOP transition.
- line_drive_low is a flop output with no combinational path from the inputs.

Decomposition:
- Package joybus_pkg holds:
  - the state enum (IDLE, DATA, STOP);
  - 4-bit quarter patterns Q_ZERO, Q_ONE, Q_STOP_CTRL, Q_STOP_CONS;
  - an encode function bit→pattern.
- One natural sub-module: joybus_quarter_timer. It is parametrised by LEVEL_CYCLES and emits quarter_idx[1:0], a quarter_end strobe and a bit_end strobe, with a synchronous clear.

Test Plan:
- LEVEL_CYCLES=2, tx_start with len=1, payload=0x80, console_stop=0 → line_drive_low pattern:
  - bit 1: 2 cycles low, 6 released;
  - then seven 0-bits, each 6 low, 2 released;
  - stop: 4 low, 4 released;
  - tx_done at edge k+72; tx_busy high for cycles k+1..k+72.
- len=3, payload 0x050000, console_stop=1 → 24 decoded bits equal 0x050000, stop is 2 low then 6 released, tx_done at edge k+200.
- tx_len=0, then tx_len=5 with MAX_BYTES=4 → tx_err pulses once for each request, and tx_busy and line_drive_low stay 0.
- Mid-frame tx_start with a different payload, then tx_start asserted in the tx_done cycle → the first is ignored and the frame is unchanged; the second starts the next frame with a 1-cycle release gap.
- reset_n pulsed low at cycle 30 of a 4-byte frame → line_drive_low drops asynchronously, no tx_done, next tx_start after release behaves normally.
- LEVEL_CYCLES=1 and LEVEL_CYCLES=5 sweep with len=MAX_BYTES and payload 0xA5A5A5A5 → decoded bits match and frame length is 33*4*LEVEL_CYCLES.
